cache_miss_refill_engine: RTL and testbench

Downstream consumer of the MSHR buffer in a cache bank. It takes the oldest pending miss entry (block address, per-word write mask, per-word store data, uuid), writes back the dirty victim line if required, and fetches the missing block word-by-word from memory. It merges the buffered store words over the fetched data, installs the line in the bank, and then acknowledges the entry so the MSHR buffer can retire it and report completion.

---
 rtl/cache_miss_refill_engine_if.sv | 52 +++++
 rtl/cache_miss_refill_engine.sv | 166 ++++++++++++++++
 tb/tb_cache_miss_refill_engine.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_miss_refill_engine_if.sv
// Bundles the MSHR head entry, victim line, memory port and fill/completion
// signals of the refill engine. The engine takes the master side; the MSHR
// buffer, cache bank and memory together form the slave side.
interface cache_miss_refill_engine_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int UUID_WIDTH  = 4
);
    // MSHR head entry
    logic                              mshr_valid;
    logic [ADDR_WIDTH-1:0]             mshr_block_addr;
    logic [BLOCK_WORDS-1:0]            mshr_write_status;
    logic [BLOCK_WORDS*WORD_WIDTH-1:0] mshr_write_block;
    logic [UUID_WIDTH-1:0]             mshr_uuid;
    logic                              mshr_ack;
    // victim line
    logic                              vict_dirty;
    logic [ADDR_WIDTH-1:0]             vict_addr;
    logic [BLOCK_WORDS*WORD_WIDTH-1:0] vict_block;
    // memory port
    logic                              mem_req;
    logic                              mem_we;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic [WORD_WIDTH-1:0]             mem_wdata;
    logic                              mem_ready;
    logic [WORD_WIDTH-1:0]             mem_rdata;
    // line install and completion
    logic                              fill_en;
    logic [ADDR_WIDTH-1:0]             fill_addr;
    logic [BLOCK_WORDS*WORD_WIDTH-1:0] fill_block;
    logic                              fill_dirty;
    logic                              done;
    logic [UUID_WIDTH-1:0]             done_uuid;
    logic                              busy;

    modport master (
        input  mshr_valid, mshr_block_addr, mshr_write_status, mshr_write_block, mshr_uuid,
        input  vict_dirty, vict_addr, vict_block,
        input  mem_ready, mem_rdata,
        output mshr_ack, mem_req, mem_we, mem_addr, mem_wdata,
        output fill_en, fill_addr, fill_block, fill_dirty, done, done_uuid, busy
    );

    modport slave (
        output mshr_valid, mshr_block_addr, mshr_write_status, mshr_write_block, mshr_uuid,
        output vict_dirty, vict_addr, vict_block,
        output mem_ready, mem_rdata,
        input  mshr_ack, mem_req, mem_we, mem_addr, mem_wdata,
        input  fill_en, fill_addr, fill_block, fill_dirty, done, done_uuid, busy
    );
endinterface

// File: rtl/cache_miss_refill_engine.sv
// Services the oldest MSHR entry: optional dirty-victim writeback, word-by-word
// refill from memory with buffered store words merged over the read data, a
// one-cycle line install, then a one-cycle completion/ack pulse.
module cache_miss_refill_engine #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int UUID_WIDTH  = 4
) (
    input logic CLK,
    input logic nRST,
    cache_miss_refill_engine_if.master bus
);
    localparam int BYTE_SHIFT = $clog2(WORD_WIDTH / 8);
    localparam int WCNT_W     = $clog2(BLOCK_WORDS);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {IDLE, WB, FETCH, FILL, DONE} state_t;

    state_t                 state_reg;
    logic [WCNT_W-1:0]      wcnt_reg;
    logic [ADDR_WIDTH-1:0]  blk_addr_reg;
    logic [ADDR_WIDTH-1:0]  vict_addr_reg;
    logic [BLOCK_WORDS-1:0] wstatus_reg;
    logic [UUID_WIDTH-1:0]  uuid_reg;
    logic [WORD_WIDTH-1:0]  store_word_reg [BLOCK_WORDS];
    logic [WORD_WIDTH-1:0]  vict_word_reg  [BLOCK_WORDS];
    logic [WORD_WIDTH-1:0]  line_word_reg  [BLOCK_WORDS];

    logic                   mem_req_reg;
    logic                   mem_we_reg;
    logic [ADDR_WIDTH-1:0]  mem_addr_reg;
    logic [WORD_WIDTH-1:0]  mem_wdata_reg;
    logic                   fill_en_reg;
    logic                   done_reg;

    logic [WORD_WIDTH-1:0]  store_word_in [BLOCK_WORDS];
    logic [WORD_WIDTH-1:0]  vict_word_in  [BLOCK_WORDS];
    logic [WCNT_W-1:0]      wcnt_inc;
    logic [WORD_WIDTH-1:0]  fetch_word;

    // Byte offset of word n within a line; the adder using it wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] word_offset(input logic [WCNT_W-1:0] n);
        return ADDR_WIDTH'(n) << BYTE_SHIFT;
    endfunction

    // Unpack incoming lines into words and pack the installed line back out.
    // The fill bus is zero outside the install strobe.
    generate
        for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_words
            assign store_word_in[gi] = bus.mshr_write_block[gi*WORD_WIDTH +: WORD_WIDTH];
            assign vict_word_in[gi]  = bus.vict_block[gi*WORD_WIDTH +: WORD_WIDTH];
            assign bus.fill_block[gi*WORD_WIDTH +: WORD_WIDTH] =
                fill_en_reg ? line_word_reg[gi] : '0;
        end
    endgenerate

    // Counter wraps naturally to 0 after the last word of a line.
    assign wcnt_inc   = wcnt_reg + WCNT_W'(1);
    // Buffered store words take priority over the data read from memory.
    assign fetch_word = wstatus_reg[wcnt_reg] ? store_word_reg[wcnt_reg] : bus.mem_rdata;

    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.fill_en    = fill_en_reg;
    assign bus.fill_addr  = fill_en_reg ? blk_addr_reg : '0;
    assign bus.fill_dirty = fill_en_reg & (|wstatus_reg);
    assign bus.done       = done_reg;
    assign bus.mshr_ack   = done_reg;
    assign bus.done_uuid  = done_reg ? uuid_reg : '0;
    assign bus.busy       = (state_reg != IDLE);

    // Refill sequencer: the memory request registers are loaded one cycle ahead
    // so that address/data stay stable until the memory accepts them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            wcnt_reg      <= '0;
            blk_addr_reg  <= '0;
            vict_addr_reg <= '0;
            wstatus_reg   <= '0;
            uuid_reg      <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            fill_en_reg   <= 1'b0;
            done_reg      <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                store_word_reg[i] <= '0;
                vict_word_reg[i]  <= '0;
                line_word_reg[i]  <= '0;
            end
        end else begin
            fill_en_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.mshr_valid) begin
                        blk_addr_reg  <= bus.mshr_block_addr;
                        wstatus_reg   <= bus.mshr_write_status;
                        uuid_reg      <= bus.mshr_uuid;
                        vict_addr_reg <= bus.vict_addr;
                        for (int i = 0; i < BLOCK_WORDS; i++) begin
                            store_word_reg[i] <= store_word_in[i];
                            vict_word_reg[i]  <= vict_word_in[i];
                        end
                        wcnt_reg    <= '0;
                        mem_req_reg <= 1'b1;
                        if (bus.vict_dirty) begin
                            state_reg     <= WB;
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= bus.vict_addr;
                            mem_wdata_reg <= vict_word_in[0];
                        end else begin
                            state_reg     <= FETCH;
                            mem_we_reg    <= 1'b0;
                            mem_addr_reg  <= bus.mshr_block_addr;
                            mem_wdata_reg <= '0;
                        end
                    end
                end
                WB: begin
                    if (bus.mem_ready) begin
                        wcnt_reg <= wcnt_inc;
                        if (wcnt_reg == LAST_WORD) begin
                            state_reg     <= FETCH;
                            mem_we_reg    <= 1'b0;
                            mem_addr_reg  <= blk_addr_reg;
                            mem_wdata_reg <= '0;
                        end else begin
                            mem_addr_reg  <= vict_addr_reg + word_offset(wcnt_inc);
                            mem_wdata_reg <= vict_word_reg[wcnt_inc];
                        end
                    end
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        line_word_reg[wcnt_reg] <= fetch_word;
                        wcnt_reg                <= wcnt_inc;
                        if (wcnt_reg == LAST_WORD) begin
                            state_reg   <= FILL;
                            mem_req_reg <= 1'b0;
                            fill_en_reg <= 1'b1;
                        end else begin
                            mem_addr_reg <= blk_addr_reg + word_offset(wcnt_inc);
                        end
                    end
                end
                FILL: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_miss_refill_engine.sv
// Bench for the refill engine: directed table of misses (clean, merge, dirty
// victim, stall, reset, held valid, address wrap) followed by random misses
// checked against a transaction-level model of memory traffic and line contents.
module tb_cache_miss_refill_engine;
    localparam int AW = 32;
    localparam int WW = 32;
    localparam int BW = 4;
    localparam int UW = 4;

    logic CLK;
    logic nRST;
    int   tests  = 0;
    int   failed = 0;
    logic [31:0] salt = 32'h0;

    cache_miss_refill_engine_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_WORDS(BW), .UUID_WIDTH(UW)) bus();

    cache_miss_refill_engine #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_WORDS(BW), .UUID_WIDTH(UW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0]  blk;
        logic [3:0]   mask;
        logic [127:0] sblk;
        logic [3:0]   uuid;
        logic         dirty;
        logic [31:0]  vaddr;
        logic [127:0] vblk;
        int           stall_j;
        int           stall_n;
        int           reset_j;
        logic         hold;
        logic [127:0] exp_fill;
        logic         exp_dirty;
        int           exp_done;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mt_t;

    vec_t tbl[7];

    // Memory contents: a fixed function of the word address, perturbed by salt.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return salt ^ (32'hA0 + ((a >> 2) & 32'h3));
    endfunction

    function automatic logic [255:0] all_outs();
        return {bus.mshr_ack, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                bus.fill_en, bus.fill_addr, bus.fill_block, bus.fill_dirty,
                bus.done, bus.done_uuid, bus.busy};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        failed++;
        $display("FAIL %s: no completion within cycle budget", name);
    endtask

    task automatic randomize_fields();
        bus.mshr_block_addr   = $urandom & 32'hFFFF_FFF0;
        bus.mshr_write_status = 4'($urandom);
        bus.mshr_write_block  = {$urandom, $urandom, $urandom, $urandom};
        bus.mshr_uuid         = 4'($urandom);
        bus.vict_dirty        = 1'($urandom);
        bus.vict_addr         = $urandom & 32'hFFFF_FFF0;
        bus.vict_block        = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Present one miss at the current negedge and follow it to completion.
    task automatic run_entry(input vec_t v, input int stalls[8]);
        mt_t  exp_q[$];
        mt_t  e;
        int   k = 0, j = 0, waited = 0, d = -1;
        int   nfill = 0, ndone = 0, nack = 0;
        logic [3:0] hold_uuid = 4'h0;
        bit   got = 0;

        if (v.dirty)
            for (int i = 0; i < BW; i++)
                exp_q.push_back('{1'b1, v.vaddr + 32'(4 * i), v.vblk[i*32 +: 32]});
        for (int i = 0; i < BW; i++)
            exp_q.push_back('{1'b0, v.blk + 32'(4 * i), 32'h0});

        bus.mshr_valid        = 1'b1;
        bus.mshr_block_addr   = v.blk;
        bus.mshr_write_status = v.mask;
        bus.mshr_write_block  = v.sblk;
        bus.mshr_uuid         = v.uuid;
        bus.vict_dirty        = v.dirty;
        bus.vict_addr         = v.vaddr;
        bus.vict_block        = v.vblk;
        bus.mem_ready         = 1'b0;

        forever begin
            @(negedge CLK);
            k++;
            if (k == 1) bus.mshr_valid = v.hold;
            if (v.hold && d < 0 && k > 0) randomize_fields();
            if (k > 300) begin
                timeout_fail("entry_timeout");
                bus.mshr_valid = 1'b0;
                return;
            end
            if (v.reset_j >= 0 && j == v.reset_j && bus.mem_req) begin
                #2 nRST = 1'b0;
                #1 check("reset_outputs_zero", all_outs(), '0);
                @(negedge CLK);
                @(negedge CLK);
                nRST = 1'b1;
                bus.mem_ready = 1'b1;
                for (int c = 0; c < 6; c++) begin
                    @(negedge CLK);
                    check("post_reset_quiet", {bus.done, bus.fill_en, bus.mshr_ack, bus.busy, bus.mem_req}, '0);
                end
                bus.mem_ready = 1'b0;
                return;
            end
            if (bus.mem_req) begin
                if (exp_q.size() == 0 || j >= 8) begin
                    check("mem_extra_request", {bus.mem_we, bus.mem_addr}, '0);
                    bus.mem_ready = 1'b1;
                end else begin
                    e = exp_q[0];
                    check("mem_txn", {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 32'h0},
                          {e.we, e.addr, e.wdata});
                    if (waited < stalls[j]) begin
                        bus.mem_ready = 1'b0;
                        waited++;
                    end else begin
                        bus.mem_ready = 1'b1;
                        bus.mem_rdata = e.we ? $urandom : mem_fn(e.addr);
                        void'(exp_q.pop_front());
                        j++;
                        waited = 0;
                    end
                end
            end else begin
                bus.mem_ready = 1'($urandom);
                bus.mem_rdata = $urandom;
            end
            if (bus.fill_en) begin
                nfill++;
                check("fill_cycle", 32'(k), 32'(v.exp_done - 1));
                check("fill_block", bus.fill_block, v.exp_fill);
                check("fill_addr_dirty", {bus.fill_addr, bus.fill_dirty}, {v.blk, v.exp_dirty});
            end
            if (bus.done) begin
                ndone++;
                d = k;
                check("done_cycle", 32'(k), 32'(v.exp_done));
                check("done_uuid_ack", {bus.done_uuid, bus.mshr_ack}, {v.uuid, 1'b1});
            end
            if (bus.mshr_ack) nack++;
            if (d >= 0 && k == d + 1) begin
                check("idle_after_done", bus.busy, 1'b0);
                check("pulse_counts", {8'(nfill), 8'(ndone), 8'(nack)}, 24'h010101);
                check("mem_txns_consumed", 32'(exp_q.size()), 32'h0);
                if (!v.hold) begin
                    bus.mshr_valid = 1'b0;
                    return;
                end
                hold_uuid = bus.mshr_uuid;
                break;
            end
        end

        // Valid stayed high: the next accept must land right after DONE.
        @(negedge CLK);
        check("reaccept_busy", {bus.busy, bus.mem_req}, 2'b11);
        bus.mshr_valid = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            bus.mem_ready = bus.mem_req;
            bus.mem_rdata = $urandom;
            if (bus.done) begin
                check("reaccept_uuid", bus.done_uuid, hold_uuid);
                got = 1;
            end
            @(negedge CLK);
        end
        if (!got) timeout_fail("reaccept_timeout");
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        int   stalls[8];
        vec_t r;
        int   nmem, tot;

        tbl[0] = '{32'h100, 4'b0000, 128'h0, 4'h3, 1'b0, 32'h0, 128'h0, 0, 0, -1, 1'b0,
                   128'h000000A3_000000A2_000000A1_000000A0, 1'b0, 6};
        tbl[1] = '{32'h100, 4'b0101, 128'h00000000_00000033_00000000_00000011, 4'h5, 1'b0, 32'h0, 128'h0,
                   0, 0, -1, 1'b0, 128'h000000A3_00000033_000000A1_00000011, 1'b1, 6};
        tbl[2] = '{32'h100, 4'b0000, 128'h0, 4'h7, 1'b1, 32'h200, 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000,
                   0, 0, -1, 1'b0, 128'h000000A3_000000A2_000000A1_000000A0, 1'b0, 10};
        tbl[3] = '{32'h100, 4'b0000, 128'h0, 4'h9, 1'b0, 32'h0, 128'h0, 1, 3, -1, 1'b0,
                   128'h000000A3_000000A2_000000A1_000000A0, 1'b0, 9};
        tbl[4] = '{32'h140, 4'b0000, 128'h0, 4'hB, 1'b0, 32'h0, 128'h0, 0, 0, 2, 1'b0,
                   128'h0, 1'b0, -1};
        tbl[5] = '{32'h300, 4'b0000, 128'h0, 4'hC, 1'b0, 32'h0, 128'h0, 0, 0, -1, 1'b1,
                   128'h000000A3_000000A2_000000A1_000000A0, 1'b0, 6};
        tbl[6] = '{32'hFFFF_FFF8, 4'b1110, 128'h44444444_33333333_22222222_11111111, 4'hE, 1'b1,
                   32'hFFFF_FFF8, 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000, 0, 0, -1, 1'b0,
                   128'h44444444_33333333_22222222_000000A2, 1'b1, 10};

        nRST = 1'b0;
        bus.mshr_valid = 1'b0;
        bus.mshr_block_addr = '0;
        bus.mshr_write_status = '0;
        bus.mshr_write_block = '0;
        bus.mshr_uuid = '0;
        bus.vict_dirty = 1'b0;
        bus.vict_addr = '0;
        bus.vict_block = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #1 check("reset_state", all_outs(), '0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        check("idle_after_reset", all_outs(), '0);

        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 8; i++) stalls[i] = 0;
            if (tbl[t].stall_n > 0) stalls[tbl[t].stall_j] = tbl[t].stall_n;
            $display("[TB] directed case %0d uuid=%0h", t, tbl[t].uuid);
            run_entry(tbl[t], stalls);
        end

        for (int t = 0; t < 40; t++) begin
            salt = $urandom;
            r.blk = $urandom & 32'hFFFF_FFF0;
            r.mask = 4'($urandom);
            r.sblk = {$urandom, $urandom, $urandom, $urandom};
            r.uuid = 4'($urandom);
            r.dirty = 1'($urandom);
            r.vaddr = $urandom & 32'hFFFF_FFF0;
            r.vblk = {$urandom, $urandom, $urandom, $urandom};
            r.stall_j = 0;
            r.stall_n = 0;
            r.reset_j = -1;
            r.hold = 1'b0;
            nmem = r.dirty ? 2 * BW : BW;
            tot = 0;
            for (int i = 0; i < 8; i++) begin
                stalls[i] = (i < nmem && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                tot += stalls[i];
            end
            for (int i = 0; i < BW; i++)
                r.exp_fill[i*32 +: 32] = r.mask[i] ? r.sblk[i*32 +: 32] : mem_fn(r.blk + 32'(4 * i));
            r.exp_dirty = |r.mask;
            r.exp_done = nmem + tot + 2;
            $display("[TB] random case %0d blk=%0h dirty=%0b stalls=%0d", t, r.blk, r.dirty, tot);
            run_entry(r, stalls);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
